// File: rtl/timer_key_entry.sv
// Keypad front-end for the microwave timer: collects an MM:SS entry, loads the down-counter digits and gates their count.
// Optional macro KEY_QUICK_START_EN: key 4'hC in IDLE loads 00:30 and starts immediately.
module timer_key_entry #(
  parameter int LOAD_PULSE_CYCLES = 1,
  parameter int MAX_SEC_TENS      = 5
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       counters_zero,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       cnt_en,
  output logic [2:0] digit_cnt,
  output logic       entry_err,
  output logic [2:0] state_o
);

  // state | meaning
  // IDLE  | buffer empty, waiting for the first digit
  // ENTRY | digits being collected, START validates
  // LOAD  | loadn held low, buffer frozen
  // RUN   | counters enabled, waiting for zero or STOP
  // PAUSE | counters held, START resumes, STOP abandons
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  localparam logic [3:0] KEY_START    = 4'hA;
  localparam logic [3:0] KEY_STOP     = 4'hB;
  localparam logic [2:0] LOAD_INIT    = 3'(LOAD_PULSE_CYCLES - 1);
  localparam logic [3:0] SEC_TENS_MAX = 4'(MAX_SEC_TENS);

  state_t     state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [2:0] digit_cnt_q, digit_cnt_d;
  logic [2:0] load_cnt_q, load_cnt_d;
  logic       loadn_q, loadn_d;
  logic       cnt_en_q, cnt_en_d;
  logic       entry_err_q, entry_err_d;

  logic is_digit, is_start, is_stop, buf_nonzero, entry_ok;

  assign is_digit    = key_valid && (key_code <= 4'd9);
  assign is_start    = key_valid && (key_code == KEY_START);
  assign is_stop     = key_valid && (key_code == KEY_STOP);
  assign buf_nonzero = |{min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
  assign entry_ok    = buf_nonzero && (sec_tens_q <= SEC_TENS_MAX);

  always_comb begin
    state_d     = state_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    digit_cnt_d = digit_cnt_q;
    load_cnt_d  = load_cnt_q;
    loadn_d     = loadn_q;
    cnt_en_d    = cnt_en_q;
    entry_err_d = 1'b0;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (is_digit) begin
          if (digit_cnt_q < 3'd4) begin
            min_tens_d  = min_ones_q;
            min_ones_d  = sec_tens_q;
            sec_tens_d  = sec_ones_q;
            sec_ones_d  = key_code;
            digit_cnt_d = digit_cnt_q + 3'd1;
            state_d     = S_ENTRY;
          end
        end else if (state_q == S_ENTRY && is_start) begin
          if (entry_ok) begin
            state_d    = S_LOAD;
            loadn_d    = 1'b0;
            load_cnt_d = LOAD_INIT;
          end else begin
            entry_err_d = 1'b1;
          end
        end else if (state_q == S_ENTRY && is_stop) begin
          min_tens_d  = 4'd0;
          min_ones_d  = 4'd0;
          sec_tens_d  = 4'd0;
          sec_ones_d  = 4'd0;
          digit_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end
`ifdef KEY_QUICK_START_EN
        else if (state_q == S_IDLE && key_valid && key_code == 4'hC) begin
          min_tens_d  = 4'd0;
          min_ones_d  = 4'd0;
          sec_tens_d  = 4'd3;
          sec_ones_d  = 4'd0;
          digit_cnt_d = 3'd4;
          state_d     = S_LOAD;
          loadn_d     = 1'b0;
          load_cnt_d  = LOAD_INIT;
        end
`endif
      end

      S_LOAD: begin
        // Counter enable rises on the same edge that releases loadn.
        if (load_cnt_q == 3'd0) begin
          loadn_d  = 1'b1;
          cnt_en_d = 1'b1;
          state_d  = S_RUN;
        end else begin
          load_cnt_d = load_cnt_q - 3'd1;
        end
      end

      S_RUN: begin
        if (counters_zero) begin
          min_tens_d  = 4'd0;
          min_ones_d  = 4'd0;
          sec_tens_d  = 4'd0;
          sec_ones_d  = 4'd0;
          digit_cnt_d = 3'd0;
          cnt_en_d    = 1'b0;
          state_d     = S_IDLE;
        end else if (is_stop) begin
          cnt_en_d = 1'b0;
          state_d  = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (is_start) begin
          cnt_en_d = 1'b1;
          state_d  = S_RUN;
        end else if (is_stop) begin
          min_tens_d  = 4'd0;
          min_ones_d  = 4'd0;
          sec_tens_d  = 4'd0;
          sec_ones_d  = 4'd0;
          digit_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        min_tens_d  = 4'd0;
        min_ones_d  = 4'd0;
        sec_tens_d  = 4'd0;
        sec_ones_d  = 4'd0;
        digit_cnt_d = 3'd0;
        load_cnt_d  = 3'd0;
        loadn_d     = 1'b1;
        cnt_en_d    = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
      digit_cnt_q <= 3'd0;
      load_cnt_q  <= 3'd0;
      loadn_q     <= 1'b1;
      cnt_en_q    <= 1'b0;
      entry_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      digit_cnt_q <= digit_cnt_d;
      load_cnt_q  <= load_cnt_d;
      loadn_q     <= loadn_d;
      cnt_en_q    <= cnt_en_d;
      entry_err_q <= entry_err_d;
    end
  end

  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign loadn     = loadn_q;
  assign cnt_en    = cnt_en_q;
  assign digit_cnt = digit_cnt_q;
  assign entry_err = entry_err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_timer_key_entry.sv
// Directed bench for timer_key_entry: entry, validation, load pulse, run/pause/stop and zero handling.
module tb_timer_key_entry;

  logic       clk = 1'b0;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       counters_zero;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, cnt_en, entry_err;
  logic [2:0] digit_cnt, state_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ENTRY = 3'd1, ST_LOAD = 3'd2, ST_RUN = 3'd3, ST_PAUSE = 3'd4;

  timer_key_entry dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
    .counters_zero(counters_zero),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .loadn(loadn), .cnt_en(cnt_en), .digit_cnt(digit_cnt), .entry_err(entry_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Key is presented for one rising edge; returns at the falling edge after it.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  function automatic logic [15:0] buf_val();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    clrn = 1'b0; key_valid = 1'b0; key_code = 4'h0; counters_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 16'(state_o), 16'(ST_IDLE));
    check("rst_buf", buf_val(), 16'h0000);
    check("rst_cnt", 16'(digit_cnt), 16'd0);
    check("rst_loadn", 16'(loadn), 16'd1);
    check("rst_cnt_en", 16'(cnt_en), 16'd0);
    check("rst_err", 16'(entry_err), 16'd0);
    clrn = 1'b1;

    press(4'd0); press(4'd1); press(4'd2); press(4'd3);
    check("entry_buf", buf_val(), 16'h0123);
    check("entry_cnt", 16'(digit_cnt), 16'd4);
    check("entry_state", 16'(state_o), 16'(ST_ENTRY));
    press(4'd9);
    check("fifth_buf", buf_val(), 16'h0123);
    check("fifth_cnt", 16'(digit_cnt), 16'd4);

    press(4'hB);
    check("entry_stop_state", 16'(state_o), 16'(ST_IDLE));
    check("entry_stop_buf", buf_val(), 16'h0000);
    check("entry_stop_cnt", 16'(digit_cnt), 16'd0);

    press(4'd1); press(4'd3); press(4'd0); press(4'd0);
    press(4'hA);
    check("start_err", 16'(entry_err), 16'd0);
    check("load_loadn", 16'(loadn), 16'd0);
    check("load_state", 16'(state_o), 16'(ST_LOAD));
    check("load_buf", buf_val(), 16'h1300);
    check("load_cnt_en", 16'(cnt_en), 16'd0);
    @(negedge clk);
    check("run_loadn", 16'(loadn), 16'd1);
    check("run_cnt_en", 16'(cnt_en), 16'd1);
    check("run_state", 16'(state_o), 16'(ST_RUN));
    check("run_buf", buf_val(), 16'h1300);

    press(4'd5);
    check("run_digit_buf", buf_val(), 16'h1300);
    press(4'hA);
    check("run_start_loadn", 16'(loadn), 16'd1);
    check("run_start_state", 16'(state_o), 16'(ST_RUN));

    press(4'hB);
    check("pause_state", 16'(state_o), 16'(ST_PAUSE));
    check("pause_cnt_en", 16'(cnt_en), 16'd0);
    press(4'd7);
    check("pause_digit_buf", buf_val(), 16'h1300);
    press(4'hA);
    check("resume_state", 16'(state_o), 16'(ST_RUN));
    check("resume_cnt_en", 16'(cnt_en), 16'd1);
    check("resume_loadn", 16'(loadn), 16'd1);
    press(4'hB);
    check("pause2_state", 16'(state_o), 16'(ST_PAUSE));
    press(4'hB);
    check("abandon_state", 16'(state_o), 16'(ST_IDLE));
    check("abandon_buf", buf_val(), 16'h0000);
    check("abandon_cnt", 16'(digit_cnt), 16'd0);

    press(4'd7); press(4'd5);
    press(4'hA);
    check("bad_err", 16'(entry_err), 16'd1);
    check("bad_state", 16'(state_o), 16'(ST_ENTRY));
    check("bad_loadn", 16'(loadn), 16'd1);
    check("bad_buf", buf_val(), 16'h0075);
    @(negedge clk);
    check("bad_err_pulse", 16'(entry_err), 16'd0);

    press(4'hB);
    press(4'd0);
    press(4'hA);
    check("zero_err", 16'(entry_err), 16'd1);
    check("zero_state", 16'(state_o), 16'(ST_ENTRY));

    press(4'hB);
    press(4'd5); press(4'd9);
    press(4'hA);
    check("max_tens_err", 16'(entry_err), 16'd0);
    check("max_tens_state", 16'(state_o), 16'(ST_LOAD));
    @(negedge clk);
    check("max_tens_run", 16'(state_o), 16'(ST_RUN));

    @(negedge clk);
    counters_zero = 1'b1; key_valid = 1'b1; key_code = 4'hB;
    @(negedge clk);
    counters_zero = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    check("zero_stop_state", 16'(state_o), 16'(ST_IDLE));
    check("zero_stop_buf", buf_val(), 16'h0000);
    check("zero_stop_cnt_en", 16'(cnt_en), 16'd0);
    check("zero_stop_cnt", 16'(digit_cnt), 16'd0);
    @(negedge clk);
    check("zero_stop_hold", 16'(state_o), 16'(ST_IDLE));

    press(4'hA);
    check("idle_start_state", 16'(state_o), 16'(ST_IDLE));
    check("idle_start_loadn", 16'(loadn), 16'd1);

    press(4'd4); press(4'hA);
    check("midload_loadn_low", 16'(loadn), 16'd0);
    #1 clrn = 1'b0;
    #1;
    check("midload_rst_loadn", 16'(loadn), 16'd1);
    check("midload_rst_state", 16'(state_o), 16'(ST_IDLE));
    @(negedge clk);
    clrn = 1'b1;

    press(4'hC);
`ifdef KEY_QUICK_START_EN
    check("quick_state", 16'(state_o), 16'(ST_LOAD));
    check("quick_loadn", 16'(loadn), 16'd0);
    check("quick_buf", buf_val(), 16'h0030);
    check("quick_cnt", 16'(digit_cnt), 16'd4);
    @(negedge clk);
    check("quick_run", 16'(state_o), 16'(ST_RUN));
    check("quick_cnt_en", 16'(cnt_en), 16'd1);
    press(4'hC);
    check("quick_run_ignore", 16'(state_o), 16'(ST_RUN));
`else
    check("quick_off_state", 16'(state_o), 16'(ST_IDLE));
    check("quick_off_loadn", 16'(loadn), 16'd1);
    check("quick_off_buf", buf_val(), 16'h0000);
    check("quick_off_cnt", 16'(digit_cnt), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
